// File: rtl/detect_faces_pkg.sv
// Shared constants, width helper and pipeline stage record for the face-detection multiplier.
package detect_faces_pkg;

   localparam int MUL_MAX_STAGE = 6;
   localparam int MUL_MAX_W     = 64;

   function automatic int mul_prod_width(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   typedef struct packed {
      logic                        valid;
      logic                        acc;
      logic signed [MUL_MAX_W-1:0] product;
   } mul_stage_t;

endpackage

// File: rtl/detect_faces_mul_core.sv
// Combinational extend-and-multiply: each operand is widened to the full product width
// according to its signedness, then multiplied as signed for an exact result.
module detect_faces_mul_core #(
   parameter int A_W      = 16,
   parameter int B_W      = 9,
   parameter int A_SIGNED = 0,
   parameter int B_SIGNED = 1,
   parameter int P_W      = A_W + B_W
) (
   input  logic [A_W-1:0]        a,
   input  logic [B_W-1:0]        b,
   output logic signed [P_W-1:0] product
);

   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;

   always_comb begin
      if (A_SIGNED != 0) a_ext = P_W'($signed(a));
      else               a_ext = $signed(P_W'(a));
      if (B_SIGNED != 0) b_ext = P_W'($signed(b));
      else               b_ext = $signed(P_W'(b));
      product = a_ext * b_ext;
   end

endmodule

// File: rtl/detect_faces_mul_pipe.sv
// Pipelined multiply / multiply-accumulate with valid/ready flow control and bubble collapse.
// Stage 1 holds operands, the product enters at stage 2, and the last stage owns the accumulator.
module detect_faces_mul_pipe
   import detect_faces_pkg::*;
#(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 2,
   parameter int din0_WIDTH  = 16,
   parameter int din1_WIDTH  = 9,
   parameter int dout_WIDTH  = 25,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  din_acc,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [dout_WIDTH-1:0] dout
);

   localparam int PROD_W = mul_prod_width(din0_WIDTH, din1_WIDTH);

   if (NUM_STAGE < 1 || NUM_STAGE > MUL_MAX_STAGE || ID < 0 ||
       PROD_W > MUL_MAX_W || dout_WIDTH > MUL_MAX_W) begin : g_param_check
      $error("detect_faces_mul_pipe: illegal parameter set");
   end

   mul_stage_t                  stage    [1:NUM_STAGE];
   mul_stage_t                  stage_in [1:NUM_STAGE];
   logic [NUM_STAGE:1]          move;
   logic [din0_WIDTH-1:0]       mul_a;
   logic [din1_WIDTH-1:0]       mul_b;
   logic signed [PROD_W-1:0]    prod;
   logic signed [MUL_MAX_W-1:0] prod_ext;
   logic [dout_WIDTH-1:0]       acc_q;
   logic                        unused_bits;

   detect_faces_mul_core #(
      .A_W      (din0_WIDTH),
      .B_W      (din1_WIDTH),
      .A_SIGNED (DIN0_SIGNED),
      .B_SIGNED (DIN1_SIGNED),
      .P_W      (PROD_W)
   ) u_core (
      .a       (mul_a),
      .b       (mul_b),
      .product (prod)
   );

   // Sign-extend to the record width; the low dout_WIDTH bits give extend-or-wrap for free.
   assign prod_ext = MUL_MAX_W'(prod);

   if (NUM_STAGE == 1) begin : g_direct
      assign mul_a = din0;
      assign mul_b = din1;
   end else begin : g_operand
      logic [din0_WIDTH-1:0] op_a;
      logic [din1_WIDTH-1:0] op_b;
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            op_a <= '0;
            op_b <= '0;
         end else if (move[1] && din_valid) begin
            op_a <= din0;
            op_b <= din1;
         end
      end
      assign mul_a = op_a;
      assign mul_b = op_b;
   end

   // A stage may load when it or any stage downstream of it is empty, or the output drains.
   always_comb begin
      logic all_full;
      all_full = 1'b1;
      move     = '0;
      for (int k = NUM_STAGE; k >= 1; k--) begin
         all_full = all_full & stage[k].valid;
         move[k]  = dout_ready | ~all_full;
      end
   end

   always_comb begin
      for (int k = 1; k <= NUM_STAGE; k++) begin
         if (k == 1) begin
            stage_in[k].valid   = din_valid;
            stage_in[k].acc     = din_acc;
            stage_in[k].product = (NUM_STAGE == 1) ? prod_ext : '0;
         end else if (k == 2) begin
            stage_in[k]         = stage[1];
            stage_in[k].product = prod_ext;
         end else begin
            stage_in[k] = stage[(k > 1) ? k - 1 : 1];
         end
      end
   end

   for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_stage
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n)    stage[k] <= '0;
         else if (move[k]) stage[k] <= stage_in[k];
      end
   end

   // Bubbles entering the last stage leave the accumulator untouched.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q <= '0;
      end else if (move[NUM_STAGE] && stage_in[NUM_STAGE].valid) begin
         acc_q <= (stage_in[NUM_STAGE].acc ? acc_q : '0)
                  + stage_in[NUM_STAGE].product[dout_WIDTH-1:0];
      end
   end

   always_comb begin
      unused_bits = 1'b0;
      for (int k = 1; k <= NUM_STAGE; k++)
         unused_bits = unused_bits ^ stage[k].acc ^ (^stage[k].product);
   end

   assign din_ready  = move[1];
   assign dout_valid = stage[NUM_STAGE].valid;
   assign dout       = acc_q;

endmodule

// File: tb/tb_detect_faces_mul_pipe.sv
// Directed bench for detect_faces_mul_pipe: four instances covering depth 1/2/6 and a signed 8x8->12 variant.
module tb_detect_faces_mul_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int sel = 0;

   logic        t_valid = 1'b0;
   logic [15:0] t_din0 = '0;
   logic [8:0]  t_din1 = '0;
   logic        t_acc = 1'b0;
   logic        t_dready = 1'b1;

   logic a_rdy, a_vld, c_rdy, c_vld, d_rdy, d_vld;
   logic [24:0] a_dout, c_dout, d_dout;
   logic o_rdy, o_vld;
   logic [24:0] o_dout;

   logic       b_valid = 1'b0;
   logic [7:0] b_din0 = '0;
   logic [7:0] b_din1 = '0;
   logic       b_acc = 1'b0;
   logic       b_dready = 1'b1;
   logic       b_rdy, b_vld;
   logic [11:0] b_dout;

   detect_faces_mul_pipe #(.NUM_STAGE(2)) dut_a (
      .ap_clk(clk), .ap_rst_n(rst_n), .din_valid(t_valid && sel == 0), .din_ready(a_rdy),
      .din0(t_din0), .din1(t_din1), .din_acc(t_acc), .dout_valid(a_vld),
      .dout_ready(sel == 0 ? t_dready : 1'b1), .dout(a_dout));

   detect_faces_mul_pipe #(.NUM_STAGE(1)) dut_c (
      .ap_clk(clk), .ap_rst_n(rst_n), .din_valid(t_valid && sel == 1), .din_ready(c_rdy),
      .din0(t_din0), .din1(t_din1), .din_acc(t_acc), .dout_valid(c_vld),
      .dout_ready(sel == 1 ? t_dready : 1'b1), .dout(c_dout));

   detect_faces_mul_pipe #(.NUM_STAGE(6)) dut_d (
      .ap_clk(clk), .ap_rst_n(rst_n), .din_valid(t_valid && sel == 2), .din_ready(d_rdy),
      .din0(t_din0), .din1(t_din1), .din_acc(t_acc), .dout_valid(d_vld),
      .dout_ready(sel == 2 ? t_dready : 1'b1), .dout(d_dout));

   detect_faces_mul_pipe #(.NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(12),
                           .DIN0_SIGNED(1), .DIN1_SIGNED(1)) dut_b (
      .ap_clk(clk), .ap_rst_n(rst_n), .din_valid(b_valid), .din_ready(b_rdy),
      .din0(b_din0), .din1(b_din1), .din_acc(b_acc), .dout_valid(b_vld),
      .dout_ready(b_dready), .dout(b_dout));

   assign o_rdy  = (sel == 0) ? a_rdy  : (sel == 1) ? c_rdy  : d_rdy;
   assign o_vld  = (sel == 0) ? a_vld  : (sel == 1) ? c_vld  : d_vld;
   assign o_dout = (sel == 0) ? a_dout : (sel == 1) ? c_dout : d_dout;

   function automatic logic [24:0] model_prod(input logic [15:0] a, input logic [8:0] b);
      longint p;
      p = longint'(a) * longint'($signed(b));
      return p[24:0];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", a_vld); end
      checks++; if (a_dout !== 25'd0) begin failures++; $display("FAIL reset_dout: got %0h expected 0", a_dout); end
      checks++; if (b_vld !== 1'b0 || b_dout !== 12'd0) begin failures++; $display("FAIL reset_b: got vld %b dout %0h expected 0/0", b_vld, b_dout); end
      rst_n = 1'b1;
      #1;
      checks++; if ({a_rdy, b_rdy, c_rdy, d_rdy} !== 4'b1111) begin failures++; $display("FAIL reset_ready: got %b expected 1111", {a_rdy, b_rdy, c_rdy, d_rdy}); end
      @(posedge clk); #1;
   endtask

   task automatic test_latency(input int s, input logic [15:0] d0, input logic [8:0] d1, input logic ac,
                               input int exp_lat, input logic [24:0] exp_dout, input string name);
      int   lat;
      logic seen;
      sel = s; t_dready = 1'b1; t_valid = 1'b1; t_din0 = d0; t_din1 = d1; t_acc = ac;
      #1;
      checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL %s_ready: got %b expected 1", name, o_rdy); end
      lat = 0; seen = 1'b0;
      while (!seen && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         t_valid = 1'b0;
         #1;
         if (o_vld === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen || lat != exp_lat) begin failures++; $display("FAIL %s_latency: got %0d (seen %b) expected %0d", name, lat, seen, exp_lat); end
      checks++; if (o_dout !== exp_dout) begin failures++; $display("FAIL %s_dout: got %0h expected %0h", name, o_dout, exp_dout); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [15:0] d0 [3];
      logic [8:0]  d1 [3];
      logic        ac [3];
      logic        ev [6];
      logic [24:0] ed [6];
      d0 = '{16'd3, 16'd5, 16'd7};
      d1 = '{9'd4, 9'h1FE, 9'd7};
      ac = '{1'b0, 1'b1, 1'b1};
      ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ed = '{25'd0, 25'd0, 25'd12, 25'd2, 25'd51, 25'd0};
      sel = 0; t_dready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 3) begin
            t_valid = 1'b1; t_din0 = d0[c]; t_din1 = d1[c]; t_acc = ac[c];
         end else begin
            t_valid = 1'b0;
         end
         #1;
         if (c < 3) begin
            checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d: got %b expected 1", c, o_rdy); end
         end
         checks++; if (o_vld !== ev[c]) begin failures++; $display("FAIL b2b_vld%0d: got %b expected %b", c, o_vld, ev[c]); end
         if (ev[c]) begin
            checks++; if (o_dout !== ed[c]) begin failures++; $display("FAIL b2b_dout%0d: got %0d expected %0d", c, o_dout, ed[c]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      logic [24:0] exp_out [4];
      logic [24:0] held;
      logic        held_v;
      int          acc_cnt, out_cnt, first_low;
      exp_out = '{25'd1, 25'd4, 25'd13, 25'd29};
      acc_cnt = 0; out_cnt = 0; first_low = -1; held_v = 1'b0; held = '0; sel = 0;
      for (int c = 0; c < 40 && out_cnt < 4; c++) begin
         t_dready = (c >= 5);
         if (acc_cnt < 4) begin
            t_valid = 1'b1; t_din0 = 16'(acc_cnt + 1); t_din1 = 9'(acc_cnt + 1); t_acc = (acc_cnt >= 2);
         end else begin
            t_valid = 1'b0;
         end
         #1;
         if (held_v) begin
            checks++; if (o_vld !== 1'b1 || o_dout !== held) begin failures++; $display("FAIL stall_hold: got vld %b dout %0d expected 1/%0d", o_vld, o_dout, held); end
         end
         if (t_valid && !o_rdy && first_low < 0) first_low = acc_cnt;
         if (o_vld && t_dready) begin
            checks++; if (o_dout !== exp_out[out_cnt]) begin failures++; $display("FAIL stall_out%0d: got %0d expected %0d", out_cnt, o_dout, exp_out[out_cnt]); end
            out_cnt++;
            held_v = 1'b0;
         end else if (o_vld) begin
            held_v = 1'b1; held = o_dout;
         end else begin
            held_v = 1'b0;
         end
         if (t_valid && o_rdy) acc_cnt++;
         @(posedge clk); #1;
      end
      t_valid = 1'b0; t_dready = 1'b1;
      checks++; if (first_low != 2) begin failures++; $display("FAIL stall_ready_fall: got after %0d accepts expected 2", first_low); end
      checks++; if (out_cnt != 4 || acc_cnt != 4) begin failures++; $display("FAIL stall_count: got %0d/%0d expected 4/4", acc_cnt, out_cnt); end
      #1;
      checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL stall_extra: got vld %b expected 0", o_vld); end
      @(posedge clk); #1;
   endtask

   task automatic test_signed();
      logic [7:0]  d0 [4];
      logic [7:0]  d1 [4];
      logic        ac [4];
      logic        ev [7];
      logic [11:0] ed [7];
      d0 = '{8'h80, 8'hFD, 8'hFF, 8'h7F};
      d1 = '{8'h80, 8'h05, 8'hFF, 8'h7F};
      ac = '{1'b0, 1'b0, 1'b1, 1'b0};
      ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ed = '{12'h0, 12'h0, 12'h000, 12'hFF1, 12'hFF2, 12'hF01, 12'h0};
      b_dready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin
            b_valid = 1'b1; b_din0 = d0[c]; b_din1 = d1[c]; b_acc = ac[c];
         end else begin
            b_valid = 1'b0;
         end
         #1;
         checks++; if (b_vld !== ev[c]) begin failures++; $display("FAIL signed_vld%0d: got %b expected %b", c, b_vld, ev[c]); end
         if (ev[c]) begin
            checks++; if (b_dout !== ed[c]) begin failures++; $display("FAIL signed_dout%0d: got %0h expected %0h", c, b_dout, ed[c]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_throttle(input int s, input string name);
      logic [24:0] q [$];
      logic [24:0] macc;
      logic [24:0] expv;
      logic        accepted;
      int          sent, got, cyc;
      macc = '0; sent = 0; got = 0; cyc = 0; sel = s; t_valid = 1'b0;
      while ((sent < 20 || got < 20) && cyc < 2000) begin
         cyc++;
         accepted = 1'b0;
         t_dready = ($urandom_range(0, 3) != 0);
         if (!t_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
            t_valid = 1'b1;
            t_din0  = 16'($urandom);
            t_din1  = 9'($urandom);
            t_acc   = (sent == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         end
         #1;
         if (o_vld && t_dready) begin
            expv = (q.size() > 0) ? q.pop_front() : 25'h0;
            checks++; if (o_dout !== expv) begin failures++; $display("FAIL %s_out%0d: got %0h expected %0h", name, got, o_dout, expv); end
            got++;
         end
         if (t_valid && o_rdy) begin
            macc = (t_acc ? macc : 25'h0) + model_prod(t_din0, t_din1);
            q.push_back(macc);
            sent++;
            accepted = 1'b1;
         end
         @(posedge clk); #1;
         if (accepted) t_valid = 1'b0;
      end
      t_valid = 1'b0; t_dready = 1'b1;
      checks++; if (got != 20 || sent != 20) begin failures++; $display("FAIL %s_count: got sent %0d recv %0d expected 20/20", name, sent, got); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic seen;
      test_latency(2, 16'd10, 9'd10, 1'b0, 6, 25'd100, "prereset");
      sel = 2; t_dready = 1'b1;
      t_valid = 1'b1; t_din0 = 16'd1; t_din1 = 9'd1; t_acc = 1'b1;
      #1;
      checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL midrst_ready0: got %b expected 1", o_rdy); end
      @(posedge clk); #1;
      #1;
      checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL midrst_ready1: got %b expected 1", o_rdy); end
      @(posedge clk); #1;
      t_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (o_vld !== 1'b0 || o_dout !== 25'd0) begin failures++; $display("FAIL midrst_clear: got vld %b dout %0d expected 0/0", o_vld, o_dout); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (o_vld !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_pulse: got %b expected 0", seen); end
      test_latency(2, 16'd2, 9'd3, 1'b1, 6, 25'd6, "postreset");
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_latency(0, 16'hFFFF, 9'h100, 1'b0, 2, 25'h1000100, "single");
      test_back_to_back();
      test_stall();
      test_signed();
      test_latency(1, 16'd100, 9'h1FD, 1'b0, 1, 25'h1FFFED4, "lat_n1");
      test_latency(2, 16'd1000, 9'h0FF, 1'b0, 6, 25'h003E418, "lat_n6");
      test_throttle(1, "thr_n1");
      test_throttle(2, "thr_n6");
      test_throttle(0, "thr_n2");
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
